// File: rtl/detector_colision.sv
// Collision judge at the consumer end of the obstacle stream.
// On each obstacle tick it checks the hero column and updates lives, score, the bonus flag and the game verdict.
module detector_colision #(
    parameter int         VIDAS       = 3,
    parameter int         INVUL_TICKS = 2,
    parameter logic [6:0] BONO_MASK   = 7'b0000001,
    parameter logic [4:0] TIPO_BONO   = 5'd16,
    parameter logic [2:0] GAME        = 3'd3,
    parameter logic [2:0] WL          = 3'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  presente,
    input  logic        clk_obstaculos,
    input  logic [20:0] display_obs,
    input  logic [4:0]  tipo_obs,
    input  logic [1:0]  mundo,
    input  logic [6:0]  pos_heroe,
    output logic        bono_tomado,
    output logic [1:0]  W_or_L,
    output logic [1:0]  vidas,
    output logic [7:0]  puntaje
);

    localparam int IW = $clog2(INVUL_TICKS + 1);

    typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;

    state_t          state, state_d;
    logic [2:0]      sync_q;
    logic            tick;
    logic [2:0]      pipe_q, pipe_d;
    logic            bono_q, bono_d;
    logic [1:0]      vidas_q, vidas_d;
    logic [7:0]      puntaje_q, puntaje_d;
    logic [IW-1:0]   invul_q, invul_d;
    logic [6:0]      col0;
    logic            in_game, bonus_col, taken, hit, dodge;

    // sync_q[1:0] is the synchronizer; sync_q[2] holds the previous value for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[1:0], clk_obstaculos};
    end

    assign tick      = sync_q[1] & ~sync_q[2];
    assign col0      = display_obs[6:0];
    assign in_game   = (presente == GAME) || (presente == WL);
    // The column reaching column 0 on this tick is the one that becomes pipe bit0 after the shift.
    assign bonus_col = pipe_q[1];
    assign taken     = bonus_col && (pos_heroe == BONO_MASK);
    assign hit       = !bonus_col && ((col0 & pos_heroe) != 7'd0) && (invul_q == '0);
    assign dodge     = !taken && !hit && (invul_q == '0) && (col0 != 7'd0);

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d   = state;
        pipe_d    = pipe_q;
        bono_d    = bono_q;
        vidas_d   = vidas_q;
        puntaje_d = puntaje_q;
        invul_d   = invul_q;

        case (state)
            IDLE: begin
                if (presente == GAME) state_d = PLAY;
            end
            PLAY: begin
                if (!in_game) begin
                    state_d = IDLE;
                end else if (tick) begin
                    pipe_d = {tipo_obs == TIPO_BONO, pipe_q[2:1]};
                    bono_d = taken && !bono_q;
                    if (hit) begin
                        vidas_d = vidas_q - 2'd1;
                        invul_d = INVUL_TICKS[IW-1:0];
                    end else if (invul_q != '0) begin
                        invul_d = invul_q - IW'(1);
                    end
                    if (dodge && puntaje_q != 8'hFF) puntaje_d = puntaje_q + 8'd1;
                    if (hit && vidas_q == 2'd1) begin
                        state_d = LOSE;
                        bono_d  = 1'b0;
                    end else if (mundo == 2'd3 && display_obs == 21'd0) begin
                        state_d = WIN;
                        bono_d  = 1'b0;
                    end
                end
            end
            WIN, LOSE: begin
                if (!in_game) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Whatever leads into IDLE, the HUD returns to its power-on values.
        if (state_d == IDLE) begin
            pipe_d    = '0;
            bono_d    = 1'b0;
            vidas_d   = VIDAS[1:0];
            puntaje_d = '0;
            invul_d   = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pipe_q    <= '0;
            bono_q    <= 1'b0;
            vidas_q   <= VIDAS[1:0];
            puntaje_q <= '0;
            invul_q   <= '0;
        end else begin
            state     <= state_d;
            pipe_q    <= pipe_d;
            bono_q    <= bono_d;
            vidas_q   <= vidas_d;
            puntaje_q <= puntaje_d;
            invul_q   <= invul_d;
        end
    end

    assign bono_tomado = bono_q && (state == PLAY);
    assign vidas       = vidas_q;
    assign puntaje     = puntaje_q;

    always_comb begin
        case (state)
            WIN:     W_or_L = 2'b10;
            LOSE:    W_or_L = 2'b01;
            default: W_or_L = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_detector_colision.sv
// Self-checking bench for detector_colision: directed scenarios plus random ticks
// compared against a tick-level game model.
module tb_detector_colision;

    localparam logic [2:0] GAME = 3'd3;
    localparam logic [2:0] WL   = 3'd4;
    localparam logic [2:0] WLCM = 3'd1;
    localparam int M_IDLE = 0, M_PLAY = 1, M_WIN = 2, M_LOSE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  presente = 3'd0;
    logic        clk_obstaculos = 1'b0;
    logic [20:0] display_obs = '0;
    logic [4:0]  tipo_obs = '0;
    logic [1:0]  mundo = '0;
    logic [6:0]  pos_heroe = '0;
    logic        bono_tomado;
    logic [1:0]  W_or_L;
    logic [1:0]  vidas;
    logic [7:0]  puntaje;
    logic [12:0] dut_vec;

    int errors = 0;
    int checks = 0;

    // Model of the game: whole-tick rules, flags of bonus columns seen since play began.
    int m_state = M_IDLE;
    int m_lives = 3;
    int m_score = 0;
    int m_invul = 0;
    bit m_bono  = 1'b0;
    bit flags[$];

    detector_colision dut (
        .clk(clk), .rst(rst), .presente(presente), .clk_obstaculos(clk_obstaculos),
        .display_obs(display_obs), .tipo_obs(tipo_obs), .mundo(mundo), .pos_heroe(pos_heroe),
        .bono_tomado(bono_tomado), .W_or_L(W_or_L), .vidas(vidas), .puntaje(puntaje)
    );

    always #5 clk = ~clk;

    assign dut_vec = {W_or_L, vidas, puntaje, bono_tomado};

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    function automatic logic [12:0] exp_vec();
        logic [1:0] w;
        w = (m_state == M_WIN) ? 2'b10 : (m_state == M_LOSE) ? 2'b01 : 2'b00;
        return {w, 2'(m_lives), 8'(m_score), (m_bono && m_state == M_PLAY)};
    endfunction

    function automatic void model_idle();
        m_state = M_IDLE;
        m_lives = 3;
        m_score = 0;
        m_invul = 0;
        m_bono  = 1'b0;
        flags.delete();
    endfunction

    function automatic void model_tick(input logic [20:0] disp, input logic [6:0] pos,
                                       input logic [4:0] tipo, input logic [1:0] mun);
        bit bcol, took, hit_now;
        logic [6:0] c;
        if (m_state != M_PLAY) return;
        c       = disp[6:0];
        bcol    = (flags.size() >= 2) ? flags[flags.size() - 2] : 1'b0;
        took    = bcol && (pos == 7'b0000001);
        hit_now = !bcol && ((c & pos) != 7'd0) && (m_invul == 0);
        if (!took && !hit_now && m_invul == 0 && c != 7'd0 && m_score < 255) m_score++;
        m_bono = took && !m_bono;
        if (hit_now) begin
            m_lives--;
            m_invul = 2;
        end else if (m_invul > 0) begin
            m_invul--;
        end
        flags.push_back(tipo == 5'd16);
        if (hit_now && m_lives == 0) begin
            m_state = M_LOSE;
            m_bono  = 1'b0;
        end else if (mun == 2'd3 && disp == 21'd0) begin
            m_state = M_WIN;
            m_bono  = 1'b0;
        end
    endfunction

    // One full obstacle period: inputs stable, rising edge of the tick source, then low half.
    task automatic do_tick(input logic [20:0] disp, input logic [6:0] pos,
                           input logic [4:0] tipo, input logic [1:0] mun);
        @(negedge clk);
        display_obs = disp;
        pos_heroe   = pos;
        tipo_obs    = tipo;
        mundo       = mun;
        clk_obstaculos = 1'b1;
        repeat (4) @(negedge clk);
        clk_obstaculos = 1'b0;
        repeat (4) @(negedge clk);
        model_tick(disp, pos, tipo, mun);
    endtask

    task automatic set_presente(input logic [2:0] p);
        @(negedge clk);
        presente = p;
        @(negedge clk);
        if (m_state == M_IDLE && p == GAME) begin
            model_idle();
            m_state = M_PLAY;
        end else if (m_state != M_IDLE && p != GAME && p != WL) begin
            model_idle();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (dut_vec !== 13'b00_11_00000000_0) begin
            $display("FAIL reset_state: got %h expected %h", dut_vec, 13'b00_11_00000000_0);
            errors++;
        end
        rst = 1'b0;
        set_presente(GAME);
        for (int i = 0; i < 5; i++) begin
            do_tick(21'd0, 7'b0001000, 5'd0, 2'd0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                $display("FAIL idle_play_tick%0d: got %h expected %h", i, dut_vec, exp_vec());
                errors++;
            end
        end
    endtask

    task automatic test_dodge();
        for (int i = 0; i < 4; i++) begin
            do_tick({14'd0, 7'b1000000}, 7'b0001000, 5'd0, 2'd0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                $display("FAIL dodge_tick%0d: got %h expected %h", i, dut_vec, exp_vec());
                errors++;
            end
        end
        checks++;
        if (puntaje !== 8'd4 || vidas !== 2'd3) begin
            $display("FAIL dodge_total: got puntaje=%0d vidas=%0d expected 4 3", puntaje, vidas);
            errors++;
        end
    endtask

    task automatic test_hits();
        logic [20:0] seq [0:3];
        seq[0] = {14'd0, 7'b0001000};
        seq[1] = {14'd0, 7'b0001000};
        seq[2] = {14'd0, 7'b1000000};
        seq[3] = {14'd0, 7'b0001000};
        for (int i = 0; i < 4; i++) begin
            do_tick(seq[i], 7'b0001000, 5'd0, 2'd0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                $display("FAIL hit_tick%0d: got %h expected %h", i, dut_vec, exp_vec());
                errors++;
            end
        end
        checks++;
        if (vidas !== 2'd1) begin
            $display("FAIL hit_invul_window: got vidas=%0d expected 1", vidas);
            errors++;
        end
        for (int i = 0; i < 6 && m_state == M_PLAY; i++) begin
            do_tick({14'd0, 7'b0001000}, 7'b0001000, 5'd0, 2'd0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                $display("FAIL hit_more%0d: got %h expected %h", i, dut_vec, exp_vec());
                errors++;
            end
        end
        set_presente(WL);
        checks++;
        if (W_or_L !== 2'b01 || vidas !== 2'd0) begin
            $display("FAIL lose_hold: got W_or_L=%b vidas=%0d expected 01 0", W_or_L, vidas);
            errors++;
        end
        set_presente(WLCM);
        checks++;
        if (dut_vec !== exp_vec()) begin
            $display("FAIL lose_exit: got %h expected %h", dut_vec, exp_vec());
            errors++;
        end
    endtask

    task automatic test_bonus();
        logic [12:0] seen [0:3];
        logic [6:0]  hero;
        set_presente(GAME);
        for (int pass = 0; pass < 2; pass++) begin
            hero = (pass == 0) ? 7'b0000001 : 7'b0000000;
            do_tick(21'd0, 7'd0, 5'd16, 2'd0);
            seen[0] = dut_vec;
            do_tick(21'd0, 7'd0, 5'd0, 2'd0);
            seen[1] = dut_vec;
            do_tick({14'd0, 7'b0000001}, hero, 5'd0, 2'd0);
            seen[2] = dut_vec;
            checks++;
            if (bono_tomado !== (pass == 0)) begin
                $display("FAIL bonus_take_p%0d: got %b expected %b", pass, bono_tomado, pass == 0);
                errors++;
            end
            do_tick(21'd0, 7'd0, 5'd0, 2'd0);
            seen[3] = dut_vec;
            checks++;
            if (bono_tomado !== 1'b0) begin
                $display("FAIL bonus_clear_p%0d: got %b expected 0", pass, bono_tomado);
                errors++;
            end
            checks++;
            if (seen[3] !== exp_vec()) begin
                $display("FAIL bonus_model_p%0d: got %h expected %h", pass, seen[3], exp_vec());
                errors++;
            end
        end
    endtask

    task automatic test_win();
        do_tick({14'd0, 7'b0000010}, 7'b0001000, 5'd0, 2'd3);
        do_tick(21'd0, 7'b0001000, 5'd0, 2'd3);
        checks++;
        if (W_or_L !== 2'b10 || dut_vec !== exp_vec()) begin
            $display("FAIL win: got %h expected %h", dut_vec, exp_vec());
            errors++;
        end
        set_presente(WLCM);
        checks++;
        if (W_or_L !== 2'b00 || vidas !== 2'd3) begin
            $display("FAIL win_exit: got W_or_L=%b vidas=%0d expected 00 3", W_or_L, vidas);
            errors++;
        end
    endtask

    task automatic test_async_reset();
        set_presente(GAME);
        do_tick({14'd0, 7'b0100000}, 7'b0100000, 5'd0, 2'd0);
        do_tick(21'd0, 7'b0100000, 5'd0, 2'd0);
        do_tick(21'd0, 7'b0100000, 5'd0, 2'd0);
        do_tick({14'd0, 7'b0100000}, 7'b0100000, 5'd0, 2'd0);
        checks++;
        if (vidas !== 2'd1 || dut_vec !== exp_vec()) begin
            $display("FAIL pre_reset: got %h expected %h", dut_vec, exp_vec());
            errors++;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dut_vec !== 13'b00_11_00000000_0) begin
            $display("FAIL async_reset: got %h expected %h", dut_vec, 13'b00_11_00000000_0);
            errors++;
        end
        model_idle();
        @(negedge clk);
        rst = 1'b0;
        set_presente(GAME);
    endtask

    task automatic test_random();
        logic [20:0] disp;
        logic [6:0]  pos;
        logic [4:0]  tipo;
        logic [1:0]  mun;
        for (int i = 0; i < 250; i++) begin
            disp = 21'($urandom);
            if ($urandom_range(0, 7) == 0) disp = 21'd0;
            if ($urandom_range(0, 3) == 0) pos = 7'd0;
            else if ($urandom_range(0, 4) == 0) pos = 7'b0000001;
            else pos = 7'(1 << $urandom_range(0, 6));
            tipo = ($urandom_range(0, 3) == 0) ? 5'd16 : 5'($urandom_range(0, 15));
            mun  = 2'($urandom_range(0, 3));
            do_tick(disp, pos, tipo, mun);
            checks++;
            if (dut_vec !== exp_vec()) begin
                $display("FAIL random_tick%0d: got %h expected %h", i, dut_vec, exp_vec());
                errors++;
            end
            if (m_state != M_PLAY || $urandom_range(0, 40) == 0) begin
                if (m_state != M_PLAY) set_presente(WL);
                set_presente(WLCM);
                checks++;
                if (dut_vec !== exp_vec()) begin
                    $display("FAIL random_exit%0d: got %h expected %h", i, dut_vec, exp_vec());
                    errors++;
                end
                set_presente(GAME);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dodge();
        test_hits();
        test_bonus();
        test_win();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
